// File: rtl/atm_pkg.sv
// atm_pkg: status/currency/state encodings, ASCII constants and character helpers shared by user_input and user_output
package atm_pkg;

    typedef enum logic [3:0] {
        STAT_NONE      = 4'd0,
        ACC_FOUND      = 4'd1,
        ACC_NOT_FOUND  = 4'd2,
        PIN_OK         = 4'd3,
        PIN_BAD        = 4'd4,
        VALUE_OK       = 4'd5,
        VALUE_BAD      = 4'd6,
        QUERY          = 4'd7,
        INPUT_COMPLETE = 4'd8
    } status_t;

    typedef enum logic [2:0] {
        USD = 3'd0,
        BTC = 3'd1,
        ETH = 3'd2,
        XRP = 3'd3,
        LTC = 3'd4
    } currency_t;

    typedef enum logic [2:0] {
        IDLE,
        PREFIX,
        DIGIT,
        SUFFIX,
        CR,
        LF,
        DONE
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_Q  = 8'h3F;

    function automatic logic [7:0] prefix_char(input logic [3:0] s);
        case (s)
            ACC_FOUND:      return 8'h41;
            ACC_NOT_FOUND:  return 8'h61;
            PIN_OK:         return 8'h50;
            PIN_BAD:        return 8'h70;
            VALUE_OK:       return 8'h56;
            VALUE_BAD:      return 8'h76;
            QUERY:          return 8'h51;
            INPUT_COMPLETE: return 8'h4B;
            default:        return ASCII_Q;
        endcase
    endfunction

    function automatic logic [7:0] suffix_char(input logic [2:0] c);
        case (c)
            USD:     return 8'h55;
            BTC:     return 8'h42;
            ETH:     return 8'h45;
            XRP:     return 8'h58;
            LTC:     return 8'h4C;
            default: return ASCII_Q;
        endcase
    endfunction

    // index of the first digit that is not '0'; the last digit is always sent
    function automatic logic [1:0] first_digit(input logic [15:0] v);
        return v[15:12] != 4'd0 ? 2'd3 : v[11:8] != 4'd0 ? 2'd2 : v[7:4] != 4'd0 ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/bin2ascii.sv
// bin2ascii: BCD nibble to ASCII digit, '?' for nibbles above 9
module bin2ascii
    import atm_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    assign ascii = nibble > 4'd9 ? ASCII_Q : ASCII_0 + {4'd0, nibble};

endmodule

// File: rtl/user_output.sv
// user_output: serialises a status message (prefix, 4 BCD digits, currency, CR, LF) over a valid/ready byte port; LEADING_ZERO_SUPPRESS_EN skips leading '0' digits
module user_output
    import atm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  status_code,
    input  logic [15:0] value,
    input  logic [2:0]  currency_type,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    state_t      state, state_n;
    logic [3:0]  st;
    logic [15:0] val;
    logic [2:0]  cur;
    logic [1:0]  idx;
    logic [7:0]  dig;
    logic        xfer, accept;

    assign xfer   = tx_valid & tx_ready;
    assign accept = start && state == IDLE;

    bin2ascii u_b2a (
        .nibble (val[{idx, 2'b00} +: 4]),
        .ascii  (dig)
    );

    // state, captured message fields and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            st    <= 4'd0;
            val   <= 16'd0;
            cur   <= 3'd0;
            idx   <= 2'd3;
        end else begin
            state <= state_n;
            if (accept) begin
                st  <= status_code;
                val <= value;
                cur <= currency_type;
`ifdef LEADING_ZERO_SUPPRESS_EN
                idx <= first_digit(value);
`else
                idx <= 2'd3;
`endif
            end else if (state == DIGIT && xfer) begin
                idx <= idx - 2'd1;
            end
        end
    end

    // next state and byte-port outputs
    always_comb begin
        state_n  = state;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        busy     = state != IDLE;
        done     = 1'b0;
        case (state)
            IDLE:   state_n = start ? PREFIX : IDLE;
            PREFIX: begin
                tx_valid = 1'b1;
                tx_data  = prefix_char(st);
                state_n  = xfer ? DIGIT : PREFIX;
            end
            DIGIT:  begin
                tx_valid = 1'b1;
                tx_data  = dig;
                state_n  = xfer && idx == 2'd0 ? SUFFIX : DIGIT;
            end
            SUFFIX: begin
                tx_valid = 1'b1;
                tx_data  = suffix_char(cur);
                state_n  = xfer ? CR : SUFFIX;
            end
            CR:     begin
                tx_valid = 1'b1;
                tx_data  = ASCII_CR;
                state_n  = xfer ? LF : CR;
            end
            LF:     begin
                tx_valid = 1'b1;
                tx_data  = ASCII_LF;
                state_n  = xfer ? DONE : LF;
            end
            DONE:   begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_user_output.sv
// tb_user_output: randomized and directed checks of user_output against a string-based message model
module tb_user_output;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  status_code = 4'd0;
    logic [15:0] value = 16'd0;
    logic [2:0]  currency_type = 3'd0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    user_output dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .status_code   (status_code),
        .value         (value),
        .currency_type (currency_type),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic void model(input logic [3:0] s, input logic [15:0] v, input logic [2:0] c);
        string pre = "AaPpVvQK";
        string suf = "UBEXL";
`ifdef LEADING_ZERO_SUPPRESS_EN
        bit lead = 1'b1;
`endif
        exp_q = {};
        exp_q.push_back((s >= 1 && s <= 8) ? pre[int'(s) - 1] : 8'h3F);
        for (int d = 3; d >= 0; d--) begin
            int n = int'((v >> (4 * d)) & 16'hF);
`ifdef LEADING_ZERO_SUPPRESS_EN
            if (lead && n == 0 && d > 0) continue;
            lead = 1'b0;
`endif
            exp_q.push_back(n > 9 ? 8'h3F : 8'(8'h30 + n));
        end
        exp_q.push_back(c < 5 ? suf[int'(c)] : 8'h3F);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    task automatic scramble();
        status_code   = 4'($urandom);
        value         = 16'($urandom);
        currency_type = 3'($urandom);
    endtask

    // starts at a negedge in IDLE, ends at the negedge of the DONE cycle
    task automatic run_msg(input logic [3:0] s, input logic [15:0] v, input logic [2:0] c,
                           input int stall, input bit meddle);
        model(s, v, c);
        status_code   = s;
        value         = v;
        currency_type = c;
        start         = 1'b1;
        tx_ready      = 1'b1;
        chk("idle_busy", busy, 0);
        @(negedge clk);
        start = 1'b0;
        scramble();
        for (int i = 0; i < exp_q.size(); i++) begin
            for (int k = 0; k < stall; k++) begin
                tx_ready = 1'b0;
                start    = meddle ? 1'($urandom) : 1'b0;
                if (meddle) scramble();
                chk($sformatf("stall_valid%0d", i), tx_valid, 1);
                chk($sformatf("stall_data%0d", i), tx_data, exp_q[i]);
                @(negedge clk);
            end
            tx_ready = 1'b1;
            start    = meddle ? 1'($urandom) : 1'b0;
            if (meddle) scramble();
            chk($sformatf("valid%0d", i), tx_valid, 1);
            chk($sformatf("data%0d", i), tx_data, exp_q[i]);
            chk($sformatf("busy%0d", i), busy, 1);
            chk($sformatf("done_early%0d", i), done, 0);
            @(negedge clk);
        end
        start = 1'b0;
        chk("done", done, 1);
        chk("done_valid", tx_valid, 0);
        chk("done_busy", busy, 1);
    endtask

    task automatic idle_chk();
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_valid", tx_valid, 0);
    endtask

    initial begin
        #1;
        chk("rst_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", tx_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_msg(4'd1, 16'h1234, 3'd1, 0, 1'b0);
        idle_chk();
        run_msg(4'd4, 16'h0042, 3'd0, 3, 1'b0);
        idle_chk();
        run_msg(4'd2, 16'h0000, 3'd2, 1, 1'b0);
        idle_chk();
        run_msg(4'd9, 16'h9A00, 3'd6, 0, 1'b0);
        idle_chk();
        run_msg(4'd5, 16'h0070, 3'd3, 2, 1'b1);
        idle_chk();

        for (int r = 0; r < 8; r++) begin
            run_msg(4'($urandom), 16'($urandom), 3'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
            idle_chk();
        end

        // reset after the third transfer aborts without done
        model(4'd3, 16'h5678, 3'd4);
        status_code   = 4'd3;
        value         = 16'h5678;
        currency_type = 3'd4;
        start         = 1'b1;
        tx_ready      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("pre_rst_data%0d", i), tx_data, exp_q[i]);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("abort_valid", tx_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_data", tx_data, 0);
        @(negedge clk);
        chk("abort_nodone", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_busy", busy, 0);
        run_msg(4'd7, 16'h0305, 3'd2, 1, 1'b0);

        // start in DONE ignored, start in the following IDLE accepted
        start         = 1'b1;
        status_code   = 4'd8;
        value         = 16'h1111;
        currency_type = 3'd0;
        @(negedge clk);
        chk("b2b_ignored_busy", busy, 0);
        chk("b2b_ignored_valid", tx_valid, 0);
        run_msg(4'd6, 16'h2468, 3'd3, 0, 1'b0);
        idle_chk();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
